// File: rtl/fpm_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpm_share_ctrl
// Purpose  : Round-robin sequencer sharing one single-precision FP multiplier
//            core between NREQ requesters. One operation is outstanding at a
//            time: accept operands, wait LATENCY cycles, capture the product,
//            return it over a valid/ready response handshake.
// Ports    : clk, rst (async, active high)
//            req_valid/req_ready/req_a/req_b : per-requester operand channel
//            rsp_valid/rsp_ready/rsp_result  : per-requester result channel
//            mul_a/mul_b/mul_result          : shared multiplier core
//            busy                            : high whenever not idle
// Options  : FPM_ZERO_BYPASS_EN - when defined, an operand with a zero
//            exponent field (zero/denormal, flushed) produces a signed zero
//            directly, skipping the core wait.
// Revision : 1.0 - initial release
// ============================================================================
module fpm_share_ctrl #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [31:0]        rsp_result,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic [31:0]        mul_result,
    output logic               busy
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [c_PTR_W-1:0]   r_gnt, w_gnt_nxt;
    logic [31:0]          r_op_a, w_op_a_nxt;
    logic [31:0]          r_op_b, w_op_b_nxt;
    logic [31:0]          r_result, w_result_nxt;
    logic [c_CNT_W-1:0]   r_count, w_count_nxt;

    logic                 w_any;
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_pick;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;

    // Round-robin search: first valid requester at or after r_rr_ptr.
    always_comb begin : p_arb
        int idx;
        w_any   = |req_valid;
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = c_PTR_W'(idx);
            end
        end
    end

    assign w_sel_a = req_a[32*w_pick +: 32];
    assign w_sel_b = req_b[32*w_pick +: 32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_op_a   <= w_op_a_nxt;
            r_op_b   <= w_op_b_nxt;
            r_result <= w_result_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_gnt_nxt    = r_gnt;
        w_op_a_nxt   = r_op_a;
        w_op_b_nxt   = r_op_b;
        w_result_nxt = r_result;
        w_count_nxt  = r_count;
        req_ready    = '0;
        rsp_valid    = '0;
        case (r_state)
            S_IDLE: begin
                // req_ready is combinational from req_valid, so it must be
                // masked by rst to keep every output low during reset.
                if (w_any && !rst) begin
                    req_ready[w_pick] = 1'b1;
                    w_gnt_nxt    = w_pick;
                    w_op_a_nxt   = w_sel_a;
                    w_op_b_nxt   = w_sel_b;
                    w_count_nxt  = c_CNT_W'(LATENCY);
                    w_rr_ptr_nxt = (w_pick == c_PTR_W'(NREQ - 1)) ? '0 : w_pick + 1'b1;
                    w_state_nxt  = S_WAIT;
`ifdef FPM_ZERO_BYPASS_EN
                    if ((w_sel_a[30:23] == 8'd0) || (w_sel_b[30:23] == 8'd0)) begin
                        w_result_nxt = {w_sel_a[31] ^ w_sel_b[31], 31'b0};
                        w_state_nxt  = S_RESP;
                    end
`endif
                end
            end
            S_WAIT: begin
                w_count_nxt = r_count - 1'b1;
                if (r_count == c_CNT_W'(1)) begin
                    w_result_nxt = mul_result;
                    w_state_nxt  = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_gnt] = 1'b1;
                if (rsp_ready[r_gnt]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rsp_result = r_result;
    assign mul_a      = r_op_a;
    assign mul_b      = r_op_b;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/fpm_share_ctrl.md
Name: fpm_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one single-precision floating-point multiplier core between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the shared core's operand inputs.
- Waits a fixed core latency, captures the product and returns it to the granted requester over a valid/ready response handshake.
- Sits between the requesting datapath units and the multiplier core instance; one operation outstanding at a time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LATENCY, 2, clock cycles from operands stable on mul_a/mul_b to mul_result valid (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  bit i: requester i presents an operand pair.
- req_ready  output  NREQ  bit i: operand pair of requester i accepted this cycle (one-hot or zero).
- req_a  input  32*NREQ  operand A of requester i in bits [32i+31:32i].
- req_b  input  32*NREQ  operand B, same packing.
- rsp_valid  output  NREQ  bit i: result for requester i is on rsp_result (one-hot or zero).
- rsp_ready  input  NREQ  bit i: requester i takes the result.
- rsp_result  output  32  product returned.
- mul_a  output  32  operand A to the shared core.
- mul_b  output  32  operand B to the shared core.
- mul_result  input  32  product from the shared core.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, op_a/op_b=0, result=0, count=0, gnt=0. All outputs 0: req_ready, rsp_valid, rsp_result, mul_a, mul_b, busy.
- mul_a/mul_b = registered op_a/op_b; they stay stable from accept until the next accept.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, gnt = first set index searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[gnt]=1 combinationally in that cycle. At the clock edge: op_a/op_b <= req_a/req_b of gnt, count <= LATENCY, rr_ptr <= (gnt+1) mod NREQ, state -> WAIT.
  - If no req_valid is set: stay in IDLE; req_ready=0.
- WAIT:
  - count decrements each cycle. When count==1: result <= mul_result, state -> RESP.
  - req_ready=0 throughout WAIT.
- RESP:
  - rsp_valid[gnt]=1 and rsp_result=result, both held stable until rsp_ready[gnt]=1.
  - On that cycle the transfer completes and state -> IDLE. rsp_ready bits of other requesters are ignored.
- Latency: accept at cycle T gives rsp_valid at T+LATENCY+1. Back-to-back throughput is one op per LATENCY+2 cycles, given an immediate rsp_ready.
- Response-stage arbitration: no new grant in RESP or WAIT, even with requests pending. A grant can be issued at the earliest in the cycle after response completion.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...
- Protocol: a requester holds req_valid and its operands until req_ready. Deasserting early is illegal; the block makes no guarantee in that case.
- Reset mid-operation: the in-flight op is discarded with no response, and rr_ptr returns to 0.
- Arithmetic: the block never alters operands or product. Sign, exponent and mantissa handling belong to the core, except under the optional feature.

Optional Feature:
- Macro: FPM_ZERO_BYPASS_EN.
- Defined:
  - At accept, if op A bits[30:23]==0 or op B bits[30:23]==0 (zero or denormal, flushed), result <= {a[31]^b[31], 31'b0} and state goes IDLE -> RESP directly, skipping WAIT.
  - That response appears at T+1. op_a/op_b still load normally.
- Undefined: all ops go through WAIT; zero operands are passed to the core unchanged.

Test Plan:
- Single op, LATENCY=2: req_valid=01, a=0x40000000 (2.0), b=0x40400000 (3.0), rsp_ready=1 -> req_ready=01 at T; rsp_valid=01 at T+3 with rsp_result = core output (0x40C00000 with a correct core); busy high T+1..T+3.
- Contention: req_valid=11 held, rsp_ready=11 -> grants 0,1,0,1; each requester receives its own product on its own rsp_valid bit.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_result are held constant; no req_ready during this time; completion when rsp_ready rises.
- Async reset asserted during WAIT -> all outputs 0 immediately; no response issued; first grant after reset goes to requester 0.
- LATENCY=1, single requester streaming -> one accept every 3 cycles; mul_a/mul_b change only on accept cycles.
- FPM_ZERO_BYPASS_EN: a=0x80000000, b=0x3F800000 -> rsp_result=0x80000000 at T+1. Without the macro, the same op responds at T+LATENCY+1.
